// File: rtl/onehot_arb_pkg.sv
// Shared types and index/one-hot helpers for the eight-requester round-robin arbiter.
package onehot_arb_pkg;

   localparam int NUM_REQ = 8;
   localparam int IDX_W   = 3;

   typedef logic [NUM_REQ-1:0] onehot_t;
   typedef logic [IDX_W-1:0]   idx_t;

   // Pointer value after reset: "last granted" is 7, so requester 0 is searched first.
   localparam idx_t PTR_RESET = idx_t'(NUM_REQ - 1);

   function automatic idx_t onehot_to_idx(input onehot_t oh);
      idx_t idx;
      idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (oh[i]) begin
            idx = idx | idx_t'(i);
         end
      end
      return idx;
   endfunction

   function automatic onehot_t idx_to_onehot(input idx_t idx);
      onehot_t oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: searches ptr+1, ptr+2, ..., ptr (mod 8) for the first request.
module rr_pick
   import onehot_arb_pkg::*;
(
   input  onehot_t req,
   input  idx_t    ptr,
   output onehot_t win,
   output idx_t    win_idx
);

   idx_t w_cand [NUM_REQ];

   // Candidate k is the (k+1)-th index after ptr; the last candidate wraps back to ptr itself.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
         assign w_cand[gi] = ptr + idx_t'(gi + 1);
      end
   endgenerate

   always_comb begin
      logic w_found;
      win     = '0;
      win_idx = ptr;
      w_found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && req[w_cand[k]]) begin
            w_found = 1'b1;
            win     = idx_to_onehot(w_cand[k]);
            win_idx = w_cand[k];
         end
      end
   end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Eight-requester round-robin arbiter with a registered one-hot select and payload output stage.
// Define RR_ARB_LOCK_EN to hold the grant on one requester until its in_last beat.
module rr_onehot_arbiter
   import onehot_arb_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_REQ-1:0]       in_valid,
   input  logic [NUM_REQ*WIDTH-1:0] in_data,
   input  logic [NUM_REQ-1:0]       in_last,
   output logic [NUM_REQ-1:0]       in_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [NUM_REQ-1:0]       out_sel,
   output logic                     out_last
);

   logic             w_load;
   logic             w_xfer;
   onehot_t          w_req;
   onehot_t          w_win;
   idx_t             w_win_idx;
   logic [WIDTH-1:0] w_data_terms [NUM_REQ];
   logic [WIDTH-1:0] w_mux_data;
   logic             w_mux_last;

   logic             r_out_valid;
   onehot_t          r_out_sel;
   logic [WIDTH-1:0] r_out_data;
   idx_t             r_ptr;

   // The output register can take a new beat when empty or being drained this cycle.
   assign w_load = ~r_out_valid | out_ready;

`ifdef RR_ARB_LOCK_EN
   logic r_locked;
   idx_t r_lock_idx;
   logic r_out_last;

   // While a packet is open only its owner is visible to the picker.
   assign w_req = r_locked ? (in_valid & idx_to_onehot(r_lock_idx)) : in_valid;
`else
   logic w_unused_last;

   assign w_unused_last = ^in_last;
   assign w_req         = in_valid;
`endif

   rr_pick u_pick (
      .req     (w_req),
      .ptr     (r_ptr),
      .win     (w_win),
      .win_idx (w_win_idx)
   );

   assign w_xfer   = w_load & (|w_win);
   assign in_ready = w_load ? w_win : '0;

   // One-hot AND-OR payload mux; w_win is zero only when nothing is loaded.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mux
         assign w_data_terms[gi] = in_data[gi*WIDTH +: WIDTH] & {WIDTH{w_win[gi]}};
      end
   endgenerate

   always_comb begin
      w_mux_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_mux_data = w_mux_data | w_data_terms[i];
      end
   end

   assign w_mux_last = |(in_last & w_win);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid <= 1'b0;
         r_out_sel   <= '0;
         r_out_data  <= '0;
      end else if (w_load) begin
         if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_sel   <= w_win;
            r_out_data  <= w_mux_data;
         end else begin
            // Drained with nothing to replace it; payload is left as-is.
            r_out_valid <= 1'b0;
            r_out_sel   <= '0;
         end
      end
   end

`ifdef RR_ARB_LOCK_EN
   // Pointer moves only when a packet closes, so a locked owner keeps its place in the rotation.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr      <= PTR_RESET;
         r_locked   <= 1'b0;
         r_lock_idx <= '0;
         r_out_last <= 1'b0;
      end else if (w_xfer) begin
         r_out_last <= w_mux_last;
         if (w_mux_last) begin
            r_ptr    <= w_win_idx;
            r_locked <= 1'b0;
         end else begin
            r_locked   <= 1'b1;
            r_lock_idx <= w_win_idx;
         end
      end
   end

   assign out_last = r_out_last;
`else
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr <= PTR_RESET;
      end else if (w_xfer) begin
         r_ptr <= w_win_idx;
      end
   end

   assign out_last = 1'b1;
`endif

   assign out_valid = r_out_valid;
   assign out_sel   = r_out_sel;
   assign out_data  = r_out_data;

endmodule
